// File: rtl/adder_seq_if.sv
// adder_seq_if: operand/result handshake bundle for adder_seq.
// Signals:
//   in_valid/in_ready   - operand handshake (producer -> adder)
//   a, b, cin, sub      - operands and mode
//   out_valid/out_ready - result handshake (adder -> consumer)
//   alu_out, carry_out  - result
//   overflow, zero      - status flags, present only with ADDER_SEQ_FLAGS_EN
// Modports: master (producer/consumer side), slave (adder side).
interface adder_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_out;
  logic             carry_out;
`ifdef ADDER_SEQ_FLAGS_EN
  logic             overflow;
  logic             zero;
`endif

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, alu_out, carry_out
`ifdef ADDER_SEQ_FLAGS_EN
    , input overflow, zero
`endif
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, alu_out, carry_out
`ifdef ADDER_SEQ_FLAGS_EN
    , output overflow, zero
`endif
  );
endinterface

// File: rtl/adder_seq.sv
// adder_seq: multi-cycle adder/subtractor, CHUNK bits per clock with the
// inter-chunk carry held in a register.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - adder_seq_if.slave: operand handshake (in_valid/in_ready, a, b,
//          cin, sub) and result handshake (out_valid/out_ready, alu_out,
//          carry_out, plus overflow/zero when ADDER_SEQ_FLAGS_EN is defined)
// Optional feature macro: ADDER_SEQ_FLAGS_EN (signed overflow and zero flags).
// Operation: sub=0 gives a+b+cin, sub=1 gives a+~b+1. Result appears
// NCHUNK edges after the input handshake and holds until out_ready.
module adder_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 4
) (
  input logic        clk,
  input logic        rst,
  adder_seq_if.slave bus
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned SUM_W  = CHUNK + 1;

  // Reject chunk sizes that do not tile the operand exactly.
  generate
    if ((CHUNK == 0) || ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
      $error("adder_seq: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] acc_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;

  logic             last_c;
  logic [SUM_W-1:0] chunk_sum_c;
  logic [WIDTH-1:0] acc_shift_c;

  // Final chunk of the operation.
  assign last_c = (cnt_q == CNT_W'(NCHUNK - 1));

  // One chunk of the ripple add, including the registered carry.
  assign chunk_sum_c = SUM_W'(opa_q[CHUNK-1:0]) + SUM_W'(opb_q[CHUNK-1:0])
                     + SUM_W'(carry_q);

  // New chunk enters from the MSB side so the result lines up after NCHUNK steps.
  always_comb begin
    acc_shift_c = acc_q >> CHUNK;
    acc_shift_c[WIDTH-1 -: CHUNK] = chunk_sum_c[CHUNK-1:0];
  end

`ifdef ADDER_SEQ_FLAGS_EN
  logic msb_cin_c;
  // Carry into the operand MSB recovered from the top bit's sum.
  assign msb_cin_c = opa_q[CHUNK-1] ^ opb_q[CHUNK-1] ^ chunk_sum_c[CHUNK-1];
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = RUN;
      RUN:     if (last_c)        state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and handshake registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
    end else begin
      state_q       <= state_d;
      bus.in_ready  <= (state_d == IDLE);
      bus.out_valid <= (state_d == DONE);
    end
  end

  // Operand capture, chunked add and result latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_q         <= '0;
      opb_q         <= '0;
      acc_q         <= '0;
      carry_q       <= 1'b0;
      cnt_q         <= '0;
      bus.alu_out   <= '0;
      bus.carry_out <= 1'b0;
`ifdef ADDER_SEQ_FLAGS_EN
      bus.overflow  <= 1'b0;
      bus.zero      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            opa_q   <= bus.a;
            opb_q   <= bus.b ^ {WIDTH{bus.sub}};
            carry_q <= bus.sub | bus.cin;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          opa_q   <= opa_q >> CHUNK;
          opb_q   <= opb_q >> CHUNK;
          acc_q   <= acc_shift_c;
          carry_q <= chunk_sum_c[CHUNK];
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last_c) begin
            bus.alu_out   <= acc_shift_c;
            bus.carry_out <= chunk_sum_c[CHUNK];
`ifdef ADDER_SEQ_FLAGS_EN
            bus.overflow  <= msb_cin_c ^ chunk_sum_c[CHUNK];
            bus.zero      <= (acc_shift_c == '0);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/adder_seq.md
Name: adder_seq

Overview:
- Parametrised multi-cycle adder/subtractor; successor to the fixed 2-bit ripple adder.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, carrying between chunks in a register, so large widths fit tight timing.
- Valid/ready handshake on input and output. Sits in the ALU datapath wherever a slow wide add is acceptable.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CHUNK, 4, bits added per cycle. WIDTH % CHUNK must be 0; elaboration error otherwise.
- NCHUNK (localparam), WIDTH/CHUNK, cycles per operation.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands/mode valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0: a+b+cin; 1: a-b computed as a+~b+1 (cin ignored).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- alu_out  output  WIDTH  sum/difference mod 2^WIDTH.
- carry_out  output  1  carry out of MSB. For sub: 1 means no borrow.
- overflow  output  1  signed overflow (only with ADDER_SEQ_FLAGS_EN).
- zero  output  1  alu_out == 0 (only with ADDER_SEQ_FLAGS_EN).

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (async): state=IDLE; in_ready=1; out_valid=0; alu_out=0; carry_out=0; overflow=0; zero=0; chunk counter=0; internal carry=0.
- IDLE: in_ready=1.
  - On in_valid&&in_ready at an edge: capture a, b^{WIDTH{sub}}, carry=sub?1:cin; counter=0; go to RUN.
  - in_valid=0: stay in IDLE; outputs hold their last values.
- RUN: in_ready=0, out_valid=0. Each edge:
  - Add the low CHUNK bits of both operand registers plus carry.
  - Shift the chunk sum into the result register from the MSB side (logical right shift of the result register).
  - Shift both operand registers right by CHUNK.
  - Update carry; counter++.
  - At the edge where counter==NCHUNK-1: latch carry_out and flags, go to DONE.
- Latency: out_valid rises exactly NCHUNK edges after the input-handshake edge. With CHUNK==WIDTH that is 1 edge.
- DONE: out_valid=1, in_ready=0. alu_out/carry_out/flags are stable until out_valid&&out_ready; at that edge go to IDLE. No new input is accepted in the same cycle (no overlap). Throughput is one operation per NCHUNK+2 cycles minimum.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
- Operand changes after capture do not affect the result in flight.
- Arithmetic: result is exact mod 2^WIDTH; carry_out is bit WIDTH of the full (WIDTH+1)-bit sum.
- Reset asserted mid-RUN or in DONE: immediate return to reset values; the in-flight operation is dropped with no output.

Optional Feature:
- Macro ADDER_SEQ_FLAGS_EN.
- Defined:
  - overflow = carry into MSB XOR carry_out, captured in the last RUN cycle.
  - zero = (final result == 0).
  - Both are registered with alu_out and valid while out_valid=1.
- Undefined: overflow and zero ports and their logic are absent; all other behaviour is identical.

Test Plan (WIDTH=8, CHUNK=2 unless stated; flag checks only apply with ADDER_SEQ_FLAGS_EN):
- a=0x5A, b=0x3C, sub=0, cin=0 -> out_valid 4 edges after handshake; alu_out=0x96, carry_out=0, overflow=1, zero=0.
- a=0xFF, b=0x01, sub=0, cin=0 -> alu_out=0x00, carry_out=1, overflow=0, zero=1. Same operands with cin=1 -> alu_out=0x01, carry_out=1, zero=0.
- a=0x10, b=0x20, sub=1, cin=1 -> cin ignored; alu_out=0xF0, carry_out=0 (borrow), overflow=0. a=0x80, b=0x01, sub=1 -> alu_out=0x7F, carry_out=1, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE and toggle a/b/in_valid -> out_valid stays 1, outputs unchanged, in_ready=0. Raise out_ready -> IDLE on the next edge, in_ready=1.
- Assert rst for 1 cycle during the 2nd RUN cycle -> immediately in_ready=1, out_valid=0, alu_out=0. No result is ever presented for the dropped operation; the next operation completes correctly.
- WIDTH=CHUNK=8: a=0x7F, b=0x01 -> out_valid 1 edge after handshake; alu_out=0x80, overflow=1.
